present80_dec: RTL and testbench

- Iterative PRESENT-80 block decryptor: one round per clock, valid/ready handshake on both input and output.
- Inverse of the existing PRESENT-80 encryption core; recovers plaintext from a ciphertext/key pair.
- Sits beside the encryptor so the board top can run encrypt→decrypt round-trip self-checks.
- Derives the last round key internally by running the key schedule forward, with an optional cache that skips this step for a repeated key.

---
 rtl/present_pkg.sv | 63 ++++++
 rtl/present80_dec_if.sv | 21 ++
 rtl/present_key_step.sv | 33 +++
 rtl/present80_dec.sv | 155 +++++++++++++++
 tb/tb_present80_dec.sv | 128 ++++++++++++
 5 files changed

// File: rtl/present_pkg.sv
// Shared PRESENT definitions: widths, S-box layers, pLayer permutation and
// the decryptor FSM state type.
package present_pkg;

    localparam int KEY_W = 80;
    localparam int BLK_W = 64;

    // Nibble x occupies bits [4x+3:4x].
    localparam logic [63:0] SBOX_TBL     = 64'h21748FE3DA09B65C;
    localparam logic [63:0] INV_SBOX_TBL = 64'hA970364BD21C8FE5;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_KEYEXP = 2'd1,
        ST_DEC    = 2'd2,
        ST_DONE   = 2'd3
    } dec_state_e;

    function automatic logic [3:0] sbox4(input logic [3:0] x);
        return SBOX_TBL[{x, 2'b00} +: 4];
    endfunction

    function automatic logic [3:0] inv_sbox4(input logic [3:0] x);
        return INV_SBOX_TBL[{x, 2'b00} +: 4];
    endfunction

    function automatic logic [BLK_W-1:0] sbox_layer(input logic [BLK_W-1:0] s);
        logic [BLK_W-1:0] r;
        for (int n = 0; n < 16; n++) begin
            r[4*n +: 4] = sbox4(s[4*n +: 4]);
        end
        return r;
    endfunction

    function automatic logic [BLK_W-1:0] inv_sbox_layer(input logic [BLK_W-1:0] s);
        logic [BLK_W-1:0] r;
        for (int n = 0; n < 16; n++) begin
            r[4*n +: 4] = inv_sbox4(s[4*n +: 4]);
        end
        return r;
    endfunction

    function automatic int p_idx(input int i);
        return (i == 63) ? 63 : ((i * 16) % 63);
    endfunction

    function automatic logic [BLK_W-1:0] p_layer(input logic [BLK_W-1:0] s);
        logic [BLK_W-1:0] r;
        for (int i = 0; i < BLK_W; i++) begin
            r[p_idx(i)] = s[i];
        end
        return r;
    endfunction

    function automatic logic [BLK_W-1:0] inv_p_layer(input logic [BLK_W-1:0] s);
        logic [BLK_W-1:0] r;
        for (int j = 0; j < BLK_W; j++) begin
            r[j] = s[p_idx(j)];
        end
        return r;
    endfunction

endpackage

// File: rtl/present80_dec_if.sv
// Handshake and data bus of the PRESENT-80 decryptor.
interface present80_dec_if;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] ciphertext;
    logic [79:0] key;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] plaintext;
    logic        busy;

    modport master (
        output in_valid, ciphertext, key, out_ready,
        input  in_ready, out_valid, plaintext, busy
    );

    modport slave (
        input  in_valid, ciphertext, key, out_ready,
        output in_ready, out_valid, plaintext, busy
    );
endinterface

// File: rtl/present_key_step.sv
// One PRESENT-80 key-schedule step; i_inv selects the inverse of the
// forward update so the decryptor can walk round keys backwards.
import present_pkg::*;

module present_key_step (
    input  logic             i_inv,
    input  logic [KEY_W-1:0] i_key,
    input  logic [4:0]       i_rnd,
    output logic [KEY_W-1:0] o_key
);

    logic [KEY_W-1:0] w_fwd;
    logic [KEY_W-1:0] w_inv;

    // Forward: rotl61, S on top nibble, counter xor. Inverse undoes in reverse order.
    always_comb begin
        w_fwd          = {i_key[18:0], i_key[79:19]};
        w_fwd[79:76]   = sbox4(w_fwd[79:76]);
        w_fwd[19:15]   = w_fwd[19:15] ^ i_rnd;

        w_inv          = i_key;
        w_inv[19:15]   = w_inv[19:15] ^ i_rnd;
        w_inv[79:76]   = inv_sbox4(w_inv[79:76]);
        w_inv          = {w_inv[60:0], w_inv[79:61]};

        if (i_inv) begin
            o_key = w_inv;
        end else begin
            o_key = w_fwd;
        end
    end

endmodule

// File: rtl/present80_dec.sv
// Iterative PRESENT-80 decryptor: forward key expansion to the last round key
// (skipped on a cached key), then one inverse round per clock.
import present_pkg::*;

module present80_dec #(
    parameter int ROUNDS    = 31,
    parameter bit KEY_CACHE = 1'b1
) (
    input  logic                   sys_clk,
    input  logic                   sys_rst,
    present80_dec_if.slave         dec_if
);

    localparam logic [4:0] RND_LAST = 5'(ROUNDS);

    dec_state_e       r_state;
    dec_state_e       w_state_nxt;
    logic [BLK_W-1:0] r_s;
    logic [KEY_W-1:0] r_key;
    logic [4:0]       r_rnd;
    logic [KEY_W-1:0] r_in_key;
    logic [KEY_W-1:0] r_cache_key;
    logic [KEY_W-1:0] r_cache_fkey;
    logic             r_cache_vld;
    logic [BLK_W-1:0] r_pt;
    logic             r_out_valid;

    logic [KEY_W-1:0] w_key_nxt;
    logic [BLK_W-1:0] w_s_nxt;
    logic             w_xfer;
    logic             w_hit;
    logic             w_dec;

    assign w_dec   = (r_state == ST_DEC);
    assign w_xfer  = dec_if.in_valid && (r_state == ST_IDLE);
    assign w_hit   = KEY_CACHE && r_cache_vld && (dec_if.key == r_cache_key);
    assign w_s_nxt = inv_sbox_layer(inv_p_layer(r_s ^ r_key[79:16]));

    present_key_step u_key_step (
        .i_inv (w_dec),
        .i_key (r_key),
        .i_rnd (r_rnd),
        .o_key (w_key_nxt)
    );

    assign dec_if.in_ready  = (r_state == ST_IDLE);
    assign dec_if.busy      = (r_state == ST_KEYEXP) || (r_state == ST_DEC);
    assign dec_if.out_valid = r_out_valid;
    assign dec_if.plaintext = r_pt;

    // FSM state register.
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_xfer) begin
                    w_state_nxt = w_hit ? ST_DEC : ST_KEYEXP;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_KEYEXP: begin
                if (r_rnd == RND_LAST) begin
                    w_state_nxt = ST_DEC;
                end else begin
                    w_state_nxt = ST_KEYEXP;
                end
            end
            ST_DEC: begin
                if (r_rnd == 5'd1) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_state_nxt = ST_DEC;
                end
            end
            ST_DONE: begin
                if (r_out_valid && dec_if.out_ready) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_DONE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Datapath, round counter, key cache and result register.
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            r_s          <= 64'd0;
            r_key        <= 80'd0;
            r_rnd        <= 5'd0;
            r_in_key     <= 80'd0;
            r_cache_key  <= 80'd0;
            r_cache_fkey <= 80'd0;
            r_cache_vld  <= 1'b0;
            r_pt         <= 64'd0;
            r_out_valid  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_xfer) begin
                        r_s      <= dec_if.ciphertext;
                        r_in_key <= dec_if.key;
                        if (w_hit) begin
                            r_key <= r_cache_fkey;
                            r_rnd <= RND_LAST;
                        end else begin
                            r_key <= dec_if.key;
                            r_rnd <= 5'd1;
                        end
                    end
                end
                ST_KEYEXP: begin
                    r_key <= w_key_nxt;
                    if (r_rnd == RND_LAST) begin
                        r_rnd        <= RND_LAST;
                        r_cache_key  <= r_in_key;
                        r_cache_fkey <= w_key_nxt;
                        r_cache_vld  <= KEY_CACHE;
                    end else begin
                        r_rnd <= r_rnd + 5'd1;
                    end
                end
                ST_DEC: begin
                    r_s   <= w_s_nxt;
                    r_key <= w_key_nxt;
                    r_rnd <= r_rnd - 5'd1;
                    if (r_rnd == 5'd1) begin
                        r_pt        <= w_s_nxt ^ w_key_nxt[79:16];
                        r_out_valid <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (dec_if.out_ready) begin
                        r_out_valid <= 1'b0;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_present80_dec.sv
// Directed-vector bench for present80_dec using the published PRESENT-80
// test vectors run in reverse.
module tb_present80_dec;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    present80_dec_if dif ();

    present80_dec #(.ROUNDS(31), .KEY_CACHE(1'b1)) dut (
        .sys_clk (clk),
        .sys_rst (rst_n),
        .dec_if  (dif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic start_op(input logic [63:0] ct, input logic [79:0] k);
        @(negedge clk);
        check("in_ready_pre", 80'(dif.in_ready), 80'd1);
        dif.ciphertext = ct;
        dif.key        = k;
        dif.in_valid   = 1'b1;
        @(posedge clk);
        #1;
        dif.in_valid   = 1'b0;
    endtask

    task automatic wait_done(input string tag, input logic [63:0] exp_pt,
                             input int exp_lat, input bit noise, input int hold);
        int n;
        n = 0;
        while (dif.out_valid !== 1'b1 && n < 200) begin
            if (noise) begin
                dif.in_valid   = (n < 20);
                dif.ciphertext = 64'({$urandom, $urandom});
                dif.key        = 80'({$urandom, $urandom, $urandom});
            end
            @(posedge clk);
            n++;
            #1;
            if (n == 5) begin
                check({tag, "_busy"}, 80'({dif.busy, dif.in_ready}), 80'd2);
            end
        end
        dif.in_valid = 1'b0;
        check({tag, "_lat"}, 80'(n), 80'(exp_lat));
        check({tag, "_pt"}, 80'(dif.plaintext), 80'(exp_pt));
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            #1;
            check({tag, "_hold_pt"}, 80'(dif.plaintext), 80'(exp_pt));
            check({tag, "_hold_rdy"}, 80'({dif.out_valid, dif.in_ready}), 80'd2);
        end
        @(negedge clk);
        dif.out_ready = 1'b1;
        @(posedge clk);
        #1;
        dif.out_ready = 1'b0;
        check({tag, "_consumed"}, 80'({dif.out_valid, dif.in_ready}), 80'd1);
    endtask

    initial begin
        n_checks       = 0;
        n_fail         = 0;
        rst_n          = 1'b0;
        dif.in_valid   = 1'b0;
        dif.out_ready  = 1'b0;
        dif.ciphertext = 64'd0;
        dif.key        = 80'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 80'(dif.out_valid), 80'd0);
        check("rst_plaintext", 80'(dif.plaintext), 80'd0);
        check("rst_busy",      80'(dif.busy),      80'd0);
        check("rst_in_ready",  80'(dif.in_ready),  80'd1);
        @(negedge clk);
        rst_n = 1'b1;

        start_op(64'h5579C1387B228445, 80'h0);
        wait_done("k0_pt0", 64'h0, 62, 1'b1, 0);

        start_op(64'hE72C46C0F5945049, 80'hFFFFFFFFFFFFFFFFFFFF);
        wait_done("kf_pt0", 64'h0, 62, 1'b0, 0);

        start_op(64'hA112FFC72F68417B, 80'h0);
        wait_done("k0_ptf", 64'hFFFFFFFFFFFFFFFF, 62, 1'b0, 0);

        start_op(64'h5579C1387B228445, 80'h0);
        wait_done("k0_hit", 64'h0, 31, 1'b0, 0);

        start_op(64'h3333DCD3213210D2, 80'hFFFFFFFFFFFFFFFFFFFF);
        wait_done("kf_ptf", 64'hFFFFFFFFFFFFFFFF, 62, 1'b0, 0);

        start_op(64'h5579C1387B228445, 80'h0);
        wait_done("hold", 64'h0, 62, 1'b0, 20);

        // Key F lands in the cache at edge 31; the reset must wipe it.
        start_op(64'hE72C46C0F5945049, 80'hFFFFFFFFFFFFFFFFFFFF);
        repeat (40) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", 80'(dif.out_valid), 80'd0);
        check("abort_busy",      80'(dif.busy),      80'd0);
        check("abort_plaintext", 80'(dif.plaintext), 80'd0);
        @(negedge clk);
        rst_n = 1'b1;

        start_op(64'hE72C46C0F5945049, 80'hFFFFFFFFFFFFFFFFFFFF);
        wait_done("post_rst", 64'h0, 62, 1'b0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
